// File: rtl/buffer_arbiter.sv
// Two-requester round-robin write arbiter feeding a buffer memory, with
// automatic and external flush sequencing.
module buffer_arbiter #(
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned CNT_W        = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] data0,
    input  logic [DATA_WIDTH-1:0] data1,
    input  logic                  flush_req,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic [DATA_WIDTH-1:0] buf_data_in,
    output logic                  buf_wr,
    output logic                  buf_flush,
    output logic [CNT_W-1:0]      fill_cnt,
    output logic                  busy
);

    typedef enum logic [0:0] {StIdle, StFlush} state_e;

    localparam logic [CNT_W-1:0] DepthC     = CNT_W'(DEPTH);
    localparam logic [3:0]       FlushLastC = 4'(FLUSH_CYCLES - 1);

    state_e                state_q, state_d;
    logic                  ptr_q, ptr_d;  // 0: req0 wins a tie, 1: req1 wins
    logic [CNT_W-1:0]      fill_cnt_q, fill_cnt_d;
    logic                  buf_wr_q, buf_wr_d;
    logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
    logic [3:0]            flush_cnt_q, flush_cnt_d;
    logic                  grant_en;

    always_comb begin
        grant_en = rst && (state_q == StIdle) && !flush_req && (fill_cnt_q != DepthC);
        gnt0     = grant_en && req0 && (!req1 || !ptr_q);
        gnt1     = grant_en && req1 && (!req0 || ptr_q);
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        fill_cnt_d  = fill_cnt_q;
        buf_wr_d    = 1'b0;
        buf_data_d  = buf_data_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            StIdle: begin
                if (flush_req) begin
                    state_d     = StFlush;
                    flush_cnt_d = 4'd0;
                end else if (gnt0 || gnt1) begin
                    buf_wr_d   = 1'b1;
                    buf_data_d = gnt0 ? data0 : data1;
                    fill_cnt_d = fill_cnt_q + 1'b1;
                    ptr_d      = gnt0;
                    // The write that fills the buffer also starts the flush.
                    if (fill_cnt_d == DepthC) begin
                        state_d     = StFlush;
                        flush_cnt_d = 4'd0;
                    end
                end
            end
            StFlush: begin
                if (flush_cnt_q == FlushLastC) begin
                    state_d     = StIdle;
                    fill_cnt_d  = '0;
                    flush_cnt_d = 4'd0;
                end else begin
                    flush_cnt_d = flush_cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            ptr_q       <= 1'b0;
            fill_cnt_q  <= '0;
            buf_wr_q    <= 1'b0;
            buf_data_q  <= '0;
            flush_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            fill_cnt_q  <= fill_cnt_d;
            buf_wr_q    <= buf_wr_d;
            buf_data_q  <= buf_data_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign buf_data_in = buf_data_q;
    assign buf_wr      = buf_wr_q;
    assign fill_cnt    = fill_cnt_q;
    assign buf_flush   = rst && (state_q == StFlush);
    assign busy        = rst && (state_q == StFlush);

endmodule

// File: doc/buffer_arbiter.md
BUFFER_ARBITER -- requirements
Module: buffer_arbiter

Interface
REQ-001 Parameter DATA_WIDTH SHALL default to 64: width of every data port.
REQ-002 Parameter DEPTH SHALL default to 8: words accepted before an automatic flush.
REQ-003 Parameter CNT_W SHALL default to 4: width of fill_cnt; must hold DEPTH.
REQ-004 Parameter FLUSH_CYCLES SHALL default to 2: length of a flush pulse in cycles, legal range 1..15.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset; synchronous and active-low.
REQ-007 req0, req1  input  1 each  requester write requests; each is held high until granted.
REQ-008 data0, data1  input  DATA_WIDTH each  requester write data; each is held stable while its req is high.
REQ-009 flush_req  input  1  external flush request.
REQ-010 gnt0, gnt1  output  1 each  combinational grants; never both high.
REQ-011 buf_data_in  output  DATA_WIDTH  registered data to the buffer memory.
REQ-012 buf_wr  output  1  registered write strobe to the buffer memory.
REQ-013 buf_flush  output  1  flush strobe to the buffer memory; decoded from the registered state.
REQ-014 fill_cnt  output  CNT_W  registered count of words written since the last flush.
REQ-015 busy  output  1  high while in FLUSH.

Function
REQ-016 The FSM SHALL have two states: IDLE and FLUSH.
REQ-017 In IDLE with flush_req=0, the arbiter SHALL assert exactly one gntX for a high reqX.
- If both reqs are high, the winner is the requester indicated by a round-robin pointer.
REQ-018 A transfer SHALL occur on each edge where reqX && gntX; on that edge:
- buf_data_in <= dataX, buf_wr <= 1;
- fill_cnt <= fill_cnt+1;
- the pointer moves to the other requester.
REQ-019 buf_wr SHALL be 0 on every edge without a transfer, giving a one-cycle strobe per word.
- Write latency is one cycle from the grant edge.
REQ-020 A single continuously requesting requester SHALL be granted on consecutive cycles when the other requester is idle.
REQ-021 With both reqs held high, grants SHALL alternate every cycle.
REQ-022 gnt0 and gnt1 SHALL both be 0 in the following cases:
- state is FLUSH;
- flush_req=1;
- fill_cnt==DEPTH.
REQ-023 flush_req=1 sampled in IDLE SHALL move the FSM to FLUSH on that edge; flush has priority over a pending request.
REQ-024 A transfer that makes fill_cnt equal DEPTH SHALL also move the FSM to FLUSH on the same edge (automatic flush).
REQ-025 In FLUSH, buf_flush and busy SHALL be high for exactly FLUSH_CYCLES cycles.
- After those cycles the FSM returns to IDLE and fill_cnt <= 0 on the exit edge.
REQ-026 flush_req asserted while in FLUSH SHALL be ignored and SHALL NOT extend or restart the flush.
REQ-027 A requester whose req drops before it is granted SHALL NOT be counted, and no write SHALL occur for it.
REQ-028 fill_cnt SHALL never exceed DEPTH and SHALL never wrap.

Reset
REQ-029 When rst=0 at a rising edge, the block SHALL apply the following values:
- state=IDLE, fill_cnt=0, pointer=req0;
- buf_wr=0, buf_data_in=0;
- the flush cycle counter=0.
REQ-030 While rst=0, gnt0, gnt1, buf_flush and busy SHALL be 0.
REQ-031 rst=0 mid-flush SHALL abort the flush.
- The block resumes in IDLE with fill_cnt=0 on the first edge after rst returns to 1.

Verification
REQ-032 Reset, then req0=1 with data0=20 for one cycle -> gnt0=1 that cycle; next cycle buf_wr=1, buf_data_in=20, fill_cnt=1.
REQ-033 req0=req1=1, data0=22, data1=50, held 4 cycles -> grants 0,1,0,1; buf_data_in 22,50,22,50; fill_cnt ends at 4.
REQ-034 Write 8 words, fill_cnt hits 8 -> FSM enters FLUSH; buf_flush=1 and busy=1 for exactly 2 cycles, no grants; then fill_cnt=0 and grants resume.
REQ-035 flush_req=1 and req1=1 in the same IDLE cycle -> no grant and no write; flush runs 2 cycles; req1 is granted on the first IDLE cycle after.
REQ-036 flush_req pulsed during FLUSH -> flush still lasts exactly FLUSH_CYCLES cycles.
REQ-037 rst=0 during the first flush cycle -> buf_flush=0 and fill_cnt=0 in the reset cycle; IDLE with pointer at req0 after release.
